// File: rtl/mii_rx_elastic_pkg.sv
// Shared encodings for the MII receive elastic buffer.
// FSM states, FIFO entry layout and the nominal CE divider.
package mii_rx_elastic_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  localparam int ENT_EOF = 5;
  localparam int ENT_ERR = 4;

  localparam int CE_DIV_NOM = 5;

  typedef struct packed {
    logic       eof;
    logic       err;
    logic [3:0] data;
  } entry_t;

  function automatic entry_t mk_entry(
    input logic       eof,
    input logic       err,
    input logic [3:0] data
  );
    entry_t e;
    e.eof  = eof;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/mii_rx_elastic_if.sv
// PCS-side nibble input and pin-driver-side output bundle.
// master = PCS/bench, slave = elastic buffer.
interface mii_rx_elastic_if;
  logic       in_ce;
  logic       in_valid;
  logic       in_err;
  logic [3:0] in_data;
  logic       ce;
  logic       valid;
  logic       err;
  logic [3:0] data;
  logic       overflow;
  logic       underflow;

  modport master (
    output in_ce, in_valid, in_err, in_data,
    input  ce, valid, err, data, overflow, underflow
  );

  modport slave (
    input  in_ce, in_valid, in_err, in_data,
    output ce, valid, err, data, overflow, underflow
  );
endinterface

// File: rtl/mii_ce_gen.sv
// Free-running output nibble strobe, one pulse every CE_DIV clocks.
// First pulse lands CE_DIV clocks after reset release.
module mii_ce_gen
  import mii_rx_elastic_pkg::*;
#(
  parameter int CE_DIV = CE_DIV_NOM
) (
  input  logic clk,
  input  logic rst_n,
  output logic ce
);

  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_q, ce_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    ce_d  = (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/mii_rx_elastic.sv
// Elastic FIFO + rate adapter feeding the MII RX pin driver.
// MII_RX_ELASTIC_STATS_EN adds saturating ovf/unf counters.
module mii_rx_elastic
  import mii_rx_elastic_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8,
  parameter int CE_DIV  = CE_DIV_NOM
) (
  input  logic              clk,
  input  logic              rst_n,
  mii_rx_elastic_if.slave   bus
`ifdef MII_RX_ELASTIC_STATS_EN
  ,
  output logic [15:0]       ovf_count,
  output logic [15:0]       unf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          ce;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d, eofs_q, eofs_d;
  logic          corrupt_q, corrupt_d, prev_v_q, prev_v_d;
  logic [1:0]    st_q, st_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [3:0]    data_q, data_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          full, empty, drop;
  logic          push, push_dat, push_eof, pop;
  entry_t        mem_q [DEPTH];
  entry_t        wdata, rdata;

  mii_ce_gen #(.CE_DIV(CE_DIV)) u_ce (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce)
  );

  // One slot stays free so the EOF marker always fits.
  always_comb begin
    full      = level_q >= LW'(DEPTH - 1);
    push_dat  = bus.in_ce && bus.in_valid && !full;
    drop      = bus.in_ce && bus.in_valid && full;
    push_eof  = bus.in_ce && !bus.in_valid && prev_v_q;
    push      = push_dat || push_eof;
    wdata     = push_eof ? mk_entry(1'b1, 1'b0, 4'h0)
                         : mk_entry(1'b0, bus.in_err | corrupt_q,
                                    bus.in_data);
    corrupt_d = drop ? 1'b1 : (push_dat ? 1'b0 : corrupt_q);
    prev_v_d  = bus.in_ce ? bus.in_valid : prev_v_q;
    ovf_d     = drop;
  end

  always_comb begin
    rdata   = mem_q[rptr_q];
    empty   = (level_q == '0);
    st_d    = st_q;
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    pop     = 1'b0;
    unf_d   = 1'b0;
    if (ce) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      data_d  = 4'h0;
      unique case (st_q)
        ST_IDLE: if (!empty) st_d = ST_FILL;
        ST_FILL: begin
          if (level_q >= LW'(PREFILL) || eofs_q != '0)
            st_d = ST_RUN;
        end
        ST_RUN: begin
          if (empty) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            unf_d   = 1'b1;
            st_d    = ST_FLUSH;
          end else begin
            pop = 1'b1;
            if (rdata.eof) begin
              st_d = ST_IDLE;
            end else begin
              valid_d = 1'b1;
              err_d   = rdata.err;
              data_d  = rdata.data;
            end
          end
        end
        ST_FLUSH: begin
          if (!empty) begin
            pop = 1'b1;
            if (rdata.eof) st_d = ST_IDLE;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
    eofs_d = eofs_q;
    if (push_eof && !(pop && rdata.eof)) eofs_d = eofs_q + 1'b1;
    if (!push_eof && (pop && rdata.eof)) eofs_d = eofs_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      eofs_q    <= '0;
      corrupt_q <= 1'b0;
      prev_v_q  <= 1'b0;
      st_q      <= ST_IDLE;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= 4'h0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      eofs_q    <= eofs_d;
      corrupt_q <= corrupt_d;
      prev_v_q  <= prev_v_d;
      st_q      <= st_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign bus.ce        = ce;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.data      = data_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

`ifdef MII_RX_ELASTIC_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d, unf_cnt_q, unf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (ovf_d && ovf_cnt_q != 16'hffff) ovf_cnt_d = ovf_cnt_q + 1'b1;
    if (unf_d && unf_cnt_q != 16'hffff) unf_cnt_d = unf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
  assign unf_count = unf_cnt_q;
`endif

endmodule
